// File: rtl/proc_pkg.sv
// Shared encodings for the accumulator-processor control unit: opcodes,
// ALU operation codes, FSM states and decode routing classes.
package proc_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int OPC_W_DEF = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LDA = 4'h7;
  localparam logic [3:0] OP_STA = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS_IMM = 3'd0;
  localparam logic [2:0] ALU_ADD      = 3'd1;
  localparam logic [2:0] ALU_SUB      = 3'd2;
  localparam logic [2:0] ALU_AND      = 3'd3;
  localparam logic [2:0] ALU_OR       = 3'd4;
  localparam logic [2:0] ALU_XOR      = 3'd5;
  localparam logic [2:0] ALU_PASS_MEM = 3'd6;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_MEMWR  = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Where DECODE sends the machine next.
  localparam logic [2:0] CLS_FETCH = 3'd0;
  localparam logic [2:0] CLS_EXEC  = 3'd1;
  localparam logic [2:0] CLS_MEMRD = 3'd2;
  localparam logic [2:0] CLS_MEMWR = 3'd3;
  localparam logic [2:0] CLS_HALT  = 3'd4;

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational opcode decoder: routing class for DECODE, ALU operation
// for the EXEC/WB write of the accumulator, and undefined-opcode flag.
module proc_ctrl_decode
  import proc_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] next_class,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    next_class = CLS_FETCH;
    alu_op     = ALU_PASS_IMM;
    illegal    = 1'b0;
    case (opcode)
      OP_NOP: next_class = CLS_FETCH;
      OP_LDI: next_class = CLS_EXEC;
      OP_ADD: begin next_class = CLS_MEMRD; alu_op = ALU_ADD;      end
      OP_SUB: begin next_class = CLS_MEMRD; alu_op = ALU_SUB;      end
      OP_AND: begin next_class = CLS_MEMRD; alu_op = ALU_AND;      end
      OP_OR:  begin next_class = CLS_MEMRD; alu_op = ALU_OR;       end
      OP_XOR: begin next_class = CLS_MEMRD; alu_op = ALU_XOR;      end
      OP_LDA: begin next_class = CLS_MEMRD; alu_op = ALU_PASS_MEM; end
      OP_STA: next_class = CLS_MEMWR;
      OP_JMP, OP_JZ, OP_OUT: next_class = CLS_EXEC;
      OP_HLT: next_class = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit of the 8-bit accumulator processor: fetches over
// a req/ack port, decodes, and sequences the datapath with one-cycle strobes.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  input  logic       mem_ack,
  input  logic [7:0] instr,
  input  logic       acc_zero,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ir_load,
  output logic       acc_we,
  output logic [2:0] alu_op,
  output logic       out_we,
  output logic       halted,
  output logic       illegal
);

  if (PC_W < 4 || OPC_W != 4) begin : g_param_check
    $error("proc_ctrl_fsm needs OPC_W == 4 and PC_W >= 4");
  end

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             ack_pend_q, ack_pend_d;
  logic [2:0]       dec_class, dec_alu_op;
  logic             dec_illegal;
  logic             in_access, ack_eff;
  logic             unused_operand;

  assign unused_operand = &{1'b0, instr[7-OPC_W:0]};

  proc_ctrl_decode u_decode (
    .opcode     (op_q),
    .next_class (dec_class),
    .alu_op     (dec_alu_op),
    .illegal    (dec_illegal)
  );

  assign in_access = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
  // An ack seen while frozen is parked here and completes the access once ena returns.
  assign ack_eff   = mem_ack || ack_pend_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ack_pend_d = ack_pend_q;
    if (ena) begin
      case (state_q)
        ST_FETCH: if (ack_eff) begin
          op_d       = instr[7 -: OPC_W];
          ack_pend_d = 1'b0;
          state_d    = ST_DECODE;
        end
        ST_DECODE: begin
          case (dec_class)
            CLS_EXEC:  state_d = ST_EXEC;
            CLS_MEMRD: state_d = ST_MEMRD;
            CLS_MEMWR: state_d = ST_MEMWR;
            CLS_HALT:  state_d = ST_HALT;
            default:   state_d = ST_FETCH;
          endcase
        end
        ST_EXEC, ST_WB: state_d = ST_FETCH;
        ST_MEMRD: if (ack_eff) begin
          ack_pend_d = 1'b0;
          state_d    = ST_WB;
        end
        ST_MEMWR: if (ack_eff) begin
          ack_pend_d = 1'b0;
          state_d    = ST_FETCH;
        end
        default: state_d = state_q;
      endcase
    end else if (in_access && mem_ack) begin
      ack_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      op_q       <= '0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  // Outputs are held low while rst is asserted so a request drops immediately.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    acc_we       = 1'b0;
    alu_op       = ALU_PASS_IMM;
    out_we       = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_load = ena && ack_eff;
          pc_inc  = ena && ack_eff;
        end
        ST_DECODE: illegal = ena && dec_illegal;
        ST_EXEC: begin
          alu_op  = dec_alu_op;
          acc_we  = ena && (op_q == OP_LDI);
          pc_load = ena && ((op_q == OP_JMP) || ((op_q == OP_JZ) && acc_zero));
          out_we  = ena && (op_q == OP_OUT);
        end
        ST_MEMRD: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
        end
        ST_MEMWR: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        ST_WB: begin
          alu_op = dec_alu_op;
          acc_we = ena;
        end
        ST_HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: builds a cycle-by-cycle expectation from an
// instruction stream using the latency and handshake rules, then replays it.
module tb_proc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       mem_ack = 1'b0;
  logic       acc_zero = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       mem_req, mem_we, mem_addr_sel;
  logic       pc_inc, pc_load, ir_load, acc_we, out_we, halted, illegal;
  logic [2:0] alu_op;

  proc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .ena(ena),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .mem_ack(mem_ack), .instr(instr), .acc_zero(acc_zero),
    .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
    .acc_we(acc_we), .alu_op(alu_op), .out_we(out_we),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, ena, ack, az;
    logic [7:0] instr;
    logic       req, we, sel, pc_inc, pc_load, ir_load, acc_we;
    logic [2:0] alu;
    logic       out_we, halted, illegal;
  } cyc_t;

  cyc_t sched[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rand_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction

  // Idle cycle: nothing expected, random noise on ack/acc_zero/instr.
  function automatic cyc_t blank();
    cyc_t c;
    c       = '0;
    c.ena   = 1'b1;
    c.ack   = coin();
    c.az    = coin();
    c.instr = 8'($urandom);
    return c;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [3:0] op);
    case (op)
      4'h2: return 3'd1;
      4'h3: return 3'd2;
      4'h4: return 3'd3;
      4'h5: return 3'd4;
      4'h6: return 3'd5;
      4'h7: return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Frozen cycles: request lines unchanged, every strobe silent.
  task automatic maybe_freeze(input cyc_t t);
    cyc_t f;
    int   n;
    if (rand_mode && $urandom_range(0, 4) == 0) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        f = t;
        f.ena = 1'b0;
        f.pc_inc = 1'b0; f.pc_load = 1'b0; f.ir_load = 1'b0;
        f.acc_we = 1'b0; f.out_we = 1'b0; f.illegal = 1'b0;
        f.ack = !t.req && coin();
        f.az  = coin();
        sched.push_back(f);
      end
    end
  endtask

  task automatic step(input cyc_t c);
    maybe_freeze(c);
    sched.push_back(c);
  endtask

  task automatic access(input bit is_fetch, input bit we, input bit sel,
                        input logic [7:0] data, input int waits, input bit late_ack);
    cyc_t t, c;
    int   n;
    t = blank();
    t.ack = 1'b0; t.req = 1'b1; t.we = we; t.sel = sel; t.instr = data;
    for (int i = 0; i < waits; i++) begin
      maybe_freeze(t);
      c = t; c.az = coin();
      sched.push_back(c);
    end
    maybe_freeze(t);
    c = t;
    if (late_ack) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        c = t; c.ena = 1'b0; c.ack = (i == 0);
        sched.push_back(c);
      end
      c = t;
    end else begin
      c.ack = 1'b1;
    end
    c.ir_load = is_fetch;
    c.pc_inc  = is_fetch;
    sched.push_back(c);
  endtask

  task automatic do_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.rst = 1'b1; c.ena = coin(); c.ack = coin(); c.az = coin();
      sched.push_back(c);
    end
  endtask

  task automatic run_instr(input logic [7:0] ins, input int fw, input bit fl,
                           input int mw, input bit ml, input bit az);
    cyc_t       c;
    logic [3:0] op;
    op = ins[7:4];
    access(1'b1, 1'b0, 1'b0, ins, fw, fl);
    c = blank();
    c.illegal = (op >= 4'hC) && (op <= 4'hE);
    step(c);
    case (op)
      4'h1: begin c = blank(); c.acc_we = 1'b1; c.alu = 3'd0; step(c); end
      4'h9: begin c = blank(); c.pc_load = 1'b1; step(c); end
      4'hB: begin c = blank(); c.az = az; c.pc_load = az; step(c); end
      4'hA: begin c = blank(); c.out_we = 1'b1; step(c); end
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        access(1'b0, 1'b0, 1'b1, 8'($urandom), mw, ml);
        c = blank(); c.acc_we = 1'b1; c.alu = exp_alu(op); step(c);
      end
      4'h8: access(1'b0, 1'b1, 1'b1, 8'($urandom), mw, ml);
      4'hF: for (int i = 0; i < 20; i++) begin
        c = blank(); c.halted = 1'b1; step(c);
      end
      default: ;
    endcase
  endtask

  task automatic build();
    cyc_t       t;
    logic [7:0] ins;
    do_reset(3);
    rand_mode = 1'b0;
    run_instr(8'h15, 0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(8'h23, 0, 1'b0, 4, 1'b0, 1'b0);
    run_instr(8'hB7, 0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(8'hB7, 0, 1'b0, 0, 1'b0, 1'b1);
    run_instr(8'hC0, 0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(8'h27, 1, 1'b0, 2, 1'b1, 1'b0);
    run_instr(8'hA0, 0, 1'b1, 0, 1'b0, 1'b0);
    run_instr(8'h00, 2, 1'b0, 0, 1'b0, 1'b0);
    run_instr(8'h83, 0, 1'b0, 1, 1'b1, 1'b0);
    // Reset in the middle of a fetch whose ack was parked during a freeze.
    t = blank(); t.ack = 1'b0; t.req = 1'b1; t.instr = 8'h15;
    sched.push_back(t);
    t.ena = 1'b0; t.ack = 1'b1;
    sched.push_back(t);
    do_reset(1);
    run_instr(8'h15, 2, 1'b0, 0, 1'b0, 1'b0);
    run_instr(8'hF0, 0, 1'b0, 0, 1'b0, 1'b0);
    do_reset(2);
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ins = 8'($urandom);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3), $urandom_range(0, 3) == 0, coin());
      if (ins[7:4] == 4'hF) do_reset($urandom_range(1, 2));
    end
  endtask

  initial begin
    cyc_t e;
    build();
    foreach (sched[i]) begin
      e = sched[i];
      @(posedge clk);
      #2;
      rst = e.rst; ena = e.ena; mem_ack = e.ack; acc_zero = e.az; instr = e.instr;
      @(negedge clk);
      cyc = i;
      check_eq("mem_req",  8'(mem_req),      8'(e.req));
      check_eq("mem_we",   8'(mem_we),       8'(e.we));
      check_eq("addr_sel", 8'(mem_addr_sel), 8'(e.sel));
      check_eq("pc_inc",   8'(pc_inc),       8'(e.pc_inc));
      check_eq("pc_load",  8'(pc_load),      8'(e.pc_load));
      check_eq("ir_load",  8'(ir_load),      8'(e.ir_load));
      check_eq("acc_we",   8'(acc_we),       8'(e.acc_we));
      if (e.acc_we) check_eq("alu_op", 8'(alu_op), 8'(e.alu));
      check_eq("out_we",   8'(out_we),       8'(e.out_we));
      check_eq("halted",   8'(halted),       8'(e.halted));
      check_eq("illegal",  8'(illegal),      8'(e.illegal));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
